td4_program_store: RTL and testbench
====================================

Name: td4_program_store

Overview:
- Instruction store and fetch stage directly upstream of the TD4 CPU core. Holds a 16 x 8-bit program.
- Supplies {opcode, immediate} for the CPU's current pc, combinationally.
- Loaded from the outside world through a nibble-serial, pin-friendly write interface.
- Gates CPU execution while a program is being loaded.

Parameters:
- ADDR_W, 4, program address width; depth = 2**ADDR_W. Fixed at 4 to match the 4-bit pc.
- SYNC_STAGES, 2, synchroniser flops on the asynchronous pin inputs load_mode and nib_valid.

Ports:
- clk  in  1  system clock
- rst_n  in  1  reset
- load_mode  in  1  1 = loader owns the memory; pin input, asynchronous
- nib_valid  in  1  strobe: nib_in is valid; pin input, asynchronous, one word half per rising edge
- nib_in  in  4  data nibble; must be stable from before the nib_valid rise until 3 clk after it
- pc  in  4  fetch address from the CPU
- opcode  out  4  instruction bits [7:4] for the CPU
- immediate  out  4  instruction bits [3:0] for the CPU
- cpu_en  out  1  1 = CPU may advance; 0 while loading
- load_addr  out  4  next address to be written
- load_wrap  out  1  one-cycle pulse when the write to address 15 completes

Behaviour:
- Reset: asynchronous, active-low on rst_n; one clock clk. The reset is asynchronous active-low.
- Values at reset:
  - all 16 entries = 8'h00 (ADD A,0, architecturally harmless);
  - state = RUN; load_addr = 0; load_wrap = 0; cpu_en = 0;
  - hold nibble = 0; synchroniser and edge flops = 0.
- Synchronisation:
  - load_mode and nib_valid each pass SYNC_STAGES flops.
  - A nib_valid rising edge is detected on the synchronised signal and gives a 1-cycle strobe, `stb`.
  - Pin rise to stb = 3 clk. nib_in is sampled (unsynchronised) on the stb cycle.
- cpu_en is registered: it is 1 in RUN from the first cycle after reset release with load_mode_sync = 0; otherwise 0.
- FSM states: RUN, LOAD_HI, LOAD_LO.
  - RUN: if load_mode_sync = 1, go to LOAD_HI, set load_addr = 0 and drop cpu_en the same edge. stb is ignored in RUN.
  - LOAD_HI: on stb, hold = nib_in and go to LOAD_LO.
  - LOAD_LO: on stb:
    - mem[load_addr] = {hold, nib_in};
    - load_addr increments mod 16;
    - go to LOAD_HI;
    - if load_addr was 15, pulse load_wrap for 1 cycle and wrap to 0.
  - Leaving load: in LOAD_HI or LOAD_LO, load_mode_sync = 0 goes to RUN. A half-captured word is discarded and memory is unchanged. load_addr keeps its value. cpu_en returns to 1 on the next cycle.
  - Simultaneous events: if load_mode_sync falls on the same cycle as stb, the exit wins and nothing is written.
- Fetch:
  - Combinational, latency 0: {opcode, immediate} = mem[pc] when cpu_en = 1.
  - When cpu_en = 0, forced to 8'h00 so the CPU sees no state-changing instruction.
  - There is no read/write collision because writes happen only when cpu_en = 0.
- Reset mid-load: all state returns to reset values, including the memory clear. Partially written programs are lost.
- Re-entry into load always restarts at address 0.

Decomposition:
- Shared package `td4_pkg` holds:
  - the opcode constants already used by the CPU (ADD_A_IM 4'b0000, ADD_B_IM 4'b1010, MOV_A_IM 4'b1100, MOV_B_IM 4'b1110, MOV_A_B 4'b1000, MOV_B_A 4'b0010);
  - NOP_WORD = 8'h00;
  - the loader state enum (RUN, LOAD_HI, LOAD_LO).
- One sub-module, `td4_pin_sync`: a parameterised N-stage synchroniser with a rising-edge pulse output, instantiated twice.
- The memory array and FSM stay in td4_program_store.

Test Plan:
- Reset behaviour:
  - Stimulus: assert rst_n = 0 mid-run, release, sweep pc 0..15.
  - Required response: opcode/immediate = 0/0 at every pc; cpu_en = 1 one cycle after the synchronised load_mode reads 0; load_wrap never pulses.
- Load then run:
  - Stimulus: load_mode = 1, then nibble pairs (C,3), (A,1), (0,2) via nib_valid pulses, then load_mode = 0.
  - Required response:
    - mem[0..2] = 8'hC3, 8'hA1, 8'h02 and load_addr = 3;
    - cpu_en = 0 throughout the load and 1 after exit;
    - pc = 1 gives opcode = 4'hA, immediate = 4'h1.
- Wrap-around:
  - Stimulus: load 16 full words, values 8'h10..8'h1F.
  - Required response: load_wrap pulses exactly 1 cycle after the 16th low nibble's stb; load_addr = 0; pc = 15 reads 8'h1F.
- Aborted half-word:
  - Stimulus: in load, send the high nibble E only, then drop load_mode.
  - Required response: the target address keeps its old value; state = RUN; a later load restarts at address 0 in LOAD_HI.
- Edge detection and latency:
  - Stimulus: hold nib_valid high for 10 clk.
  - Required response: exactly one nibble is captured, 3 clk after the rise.
- Exit/strobe race:
  - Stimulus: in load, drive load_mode low and a low-nibble nib_valid rise simultaneously.
  - Required response: no memory write occurs.
- Reset mid-load:
  - Stimulus: assert reset mid-load.
  - Required response: all entries = 0 and state = RUN.

Source files
------------

// File: rtl/td4_pkg.sv
// Shared TD4 definitions: CPU opcodes, the harmless fetch word, loader states.
package td4_pkg;

    localparam logic [3:0] ADD_A_IM = 4'b0000;
    localparam logic [3:0] ADD_B_IM = 4'b1010;
    localparam logic [3:0] MOV_A_IM = 4'b1100;
    localparam logic [3:0] MOV_B_IM = 4'b1110;
    localparam logic [3:0] MOV_A_B  = 4'b1000;
    localparam logic [3:0] MOV_B_A  = 4'b0010;

    // ADD A,0: changes no architectural state
    localparam logic [7:0] NOP_WORD = 8'h00;

    typedef enum logic [1:0] {
        StRun,
        StLoadHi,
        StLoadLo
    } load_state_e;

endpackage

// File: rtl/td4_pin_sync.sv
// N-stage synchroniser for an asynchronous pin, with a one-cycle rising-edge pulse.
module td4_pin_sync #(
    parameter int unsigned Stages = 2
) (
    input  logic clk,
    input  logic rst_n,
    input  logic d_i,
    output logic q_o,
    output logic rise_o
);

    logic [Stages-1:0] sync_q;
    logic              prev_q;

    // Shift the pin through the synchroniser chain and remember the last synced value
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
            prev_q <= 1'b0;
        end else begin
            sync_q <= {sync_q[Stages-2:0], d_i};
            prev_q <= sync_q[Stages-1];
        end
    end

    // Level output and rising-edge strobe from the last synchroniser stage
    always_comb begin
        q_o    = sync_q[Stages-1];
        rise_o = sync_q[Stages-1] & ~prev_q;
    end

endmodule

// File: rtl/td4_program_store.sv
// TD4 program memory (16 x 8) with nibble-serial loader and gated combinational fetch.
module td4_program_store
    import td4_pkg::*;
#(
    parameter int unsigned ADDR_W      = 4,
    parameter int unsigned SYNC_STAGES = 2
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              load_mode_i,
    input  logic              nib_valid_i,
    input  logic [3:0]        nib_in_i,
    input  logic [ADDR_W-1:0] pc_i,
    output logic [3:0]        opcode_o,
    output logic [3:0]        immediate_o,
    output logic              cpu_en_o,
    output logic [ADDR_W-1:0] load_addr_o,
    output logic              load_wrap_o
);

    localparam int unsigned Depth = 2 ** ADDR_W;

    logic              lm_sync;
    logic              lm_rise_unused;
    logic              nv_sync_unused;
    logic              stb;

    load_state_e       state_q, state_d;
    logic [ADDR_W-1:0] load_addr_q, load_addr_d;
    logic [3:0]        hold_q, hold_d;
    logic              wrap_q, wrap_d;
    logic              cpu_en_q, cpu_en_d;
    logic              we;
    logic [7:0]        mem_q [Depth];
    logic [7:0]        fetch_word;

    td4_pin_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_load_mode (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (load_mode_i),
        .q_o    (lm_sync),
        .rise_o (lm_rise_unused)
    );

    td4_pin_sync #(
        .Stages (SYNC_STAGES)
    ) u_sync_nib_valid (
        .clk    (clk),
        .rst_n  (rst_n),
        .d_i    (nib_valid_i),
        .q_o    (nv_sync_unused),
        .rise_o (stb)
    );

    // Loader FSM next state; leaving load mode takes priority over a coincident strobe
    always_comb begin
        state_d     = state_q;
        load_addr_d = load_addr_q;
        hold_d      = hold_q;
        wrap_d      = 1'b0;
        we          = 1'b0;
        cpu_en_d    = (state_q == StRun) && !lm_sync;
        unique case (state_q)
            StRun: begin
                if (lm_sync) begin
                    state_d     = StLoadHi;
                    load_addr_d = '0;
                end
            end
            StLoadHi: begin
                if (!lm_sync) begin
                    state_d = StRun;
                end else if (stb) begin
                    hold_d  = nib_in_i;
                    state_d = StLoadLo;
                end
            end
            StLoadLo: begin
                if (!lm_sync) begin
                    state_d = StRun;
                end else if (stb) begin
                    we          = 1'b1;
                    load_addr_d = load_addr_q + 1'b1;
                    wrap_d      = (load_addr_q == '1);
                    state_d     = StLoadHi;
                end
            end
            default: state_d = StRun;
        endcase
    end

    // Loader state, address, held high nibble, wrap pulse and CPU enable
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= StRun;
            load_addr_q <= '0;
            hold_q      <= 4'h0;
            wrap_q      <= 1'b0;
            cpu_en_q    <= 1'b0;
        end else begin
            state_q     <= state_d;
            load_addr_q <= load_addr_d;
            hold_q      <= hold_d;
            wrap_q      <= wrap_d;
            cpu_en_q    <= cpu_en_d;
        end
    end

    // Program array: cleared by reset, written one full word per low-nibble strobe
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            for (int unsigned i = 0; i < Depth; i++) begin
                mem_q[i] <= NOP_WORD;
            end
        end else if (we) begin
            mem_q[load_addr_q] <= {hold_q, nib_in_i};
        end
    end

    // Zero-latency fetch, forced to a NOP while the CPU is held
    always_comb begin
        fetch_word  = cpu_en_q ? mem_q[pc_i] : NOP_WORD;
        opcode_o    = fetch_word[7:4];
        immediate_o = fetch_word[3:0];
        cpu_en_o    = cpu_en_q;
        load_addr_o = load_addr_q;
        load_wrap_o = wrap_q;
    end

endmodule

// File: tb/tb_td4_program_store.sv
// Scoreboard bench for td4_program_store: stimulus pushes expectations, monitor compares.
module tb_td4_program_store;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       load_mode = 1'b0;
    logic       nib_valid = 1'b0;
    logic [3:0] nib_in = 4'h0;
    logic [3:0] pc = 4'h0;
    logic [3:0] opcode;
    logic [3:0] immediate;
    logic       cpu_en;
    logic [3:0] load_addr;
    logic       load_wrap;

    td4_program_store #(
        .ADDR_W      (4),
        .SYNC_STAGES (2)
    ) dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .load_mode_i (load_mode),
        .nib_valid_i (nib_valid),
        .nib_in_i    (nib_in),
        .pc_i        (pc),
        .opcode_o    (opcode),
        .immediate_o (immediate),
        .cpu_en_o    (cpu_en),
        .load_addr_o (load_addr),
        .load_wrap_o (load_wrap)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    typedef struct {
        string       name;
        logic [12:0] exp;
    } obs_t;

    obs_t obs_q[$];
    int   wrap_q[$];
    int   checks = 0;
    int   passes = 0;

    // Reference model of the programmer-visible state
    logic [7:0] m_mem [16];
    logic [3:0] m_addr = 4'h0;
    logic [3:0] m_hold = 4'h0;
    bit         m_loading = 1'b0;
    bit         m_have_hi = 1'b0;
    bit         m_en = 1'b0;

    obs_t        mon_o;
    logic [12:0] mon_got;
    int          mon_e;

    // Monitor: one queued observation per falling edge, plus every load_wrap pulse
    always @(negedge clk) begin
        if (obs_q.size() > 0) begin
            mon_o   = obs_q.pop_front();
            mon_got = {cpu_en, load_addr, opcode, immediate};
            checks++;
            if (mon_got === mon_o.exp) passes++;
            else $display("FAIL %s: got en/addr/word=%h required %h", mon_o.name, mon_got,
                          mon_o.exp);
        end
        if (load_wrap !== 1'b0) begin
            checks++;
            if (wrap_q.size() == 0) begin
                $display("FAIL wrap_unexpected: got load_wrap=%b at cycle %0d required 0",
                         load_wrap, cyc);
            end else begin
                mon_e = wrap_q.pop_front();
                if (mon_e == cyc) passes++;
                else $display("FAIL wrap_timing: got pulse at cycle %0d required %0d", cyc,
                              mon_e);
            end
        end
    end

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic obs(input string nm, input logic [3:0] p);
        obs_t o;
        logic [7:0] w;
        pc = p;
        w = m_en ? m_mem[p] : 8'h00;
        o.name = nm;
        o.exp = {m_en, m_addr, w};
        obs_q.push_back(o);
        tick();
    endtask

    task automatic set_mode(input bit v);
        load_mode = v;
        repeat (5) tick();
        m_loading = v;
        m_en = !v;
        m_have_hi = 1'b0;
        if (v) m_addr = 4'h0;
    endtask

    // One nibble: nib_in changes right after the capture edge to pin down the latency
    task automatic send_nib(input logic [3:0] n, input int hold = 4);
        nib_in = n;
        nib_valid = 1'b1;
        if (m_loading) begin
            if (!m_have_hi) begin
                m_hold = n;
                m_have_hi = 1'b1;
            end else begin
                m_mem[m_addr] = {m_hold, n};
                if (m_addr == 4'hF) wrap_q.push_back(cyc + 3);
                m_addr = m_addr + 4'h1;
                m_have_hi = 1'b0;
            end
        end
        repeat (3) tick();
        nib_in = ~n;
        repeat (hold - 3) tick();
        nib_valid = 1'b0;
        repeat (4) tick();
    endtask

    task automatic send_word(input logic [7:0] b);
        send_nib(b[7:4]);
        send_nib(b[3:0]);
    endtask

    // Low nibble and load exit arrive together: nothing may be written
    task automatic race(input logic [3:0] n);
        nib_in = n;
        nib_valid = 1'b1;
        load_mode = 1'b0;
        repeat (5) tick();
        nib_valid = 1'b0;
        repeat (4) tick();
        m_loading = 1'b0;
        m_en = 1'b1;
        m_have_hi = 1'b0;
    endtask

    task automatic do_reset();
        rst_n = 1'b0;
        load_mode = 1'b0;
        nib_valid = 1'b0;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        m_addr = 4'h0;
        m_loading = 1'b0;
        m_have_hi = 1'b0;
        m_en = 1'b0;
        tick();
        obs("rst_held", 4'h5);
        rst_n = 1'b1;
        obs("rst_release_en0", 4'h3);
        m_en = 1'b1;
        for (int i = 0; i < 16; i++) obs("rst_sweep", 4'(i));
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        int n;
        for (int i = 0; i < 16; i++) m_mem[i] = 8'h00;
        repeat (2) tick();
        do_reset();

        // Load three words then run
        set_mode(1'b1);
        obs("load_entry", 4'h1);
        send_word(8'hC3);
        send_word(8'hA1);
        send_word(8'h02);
        obs("load_addr3", 4'h1);
        set_mode(1'b0);
        obs("run_pc1", 4'h1);
        obs("run_pc0", 4'h0);
        obs("run_pc2", 4'h2);

        // Aborted half-word, then re-entry restarts at 0
        set_mode(1'b1);
        send_word(8'h5A);
        send_nib(4'hE);
        set_mode(1'b0);
        obs("abort_pc1_kept", 4'h1);
        obs("abort_pc0", 4'h0);
        set_mode(1'b1);
        obs("reentry_addr0", 4'h0);
        send_word(8'h77);
        set_mode(1'b0);
        obs("reentry_pc0", 4'h0);
        obs("reentry_pc1", 4'h1);

        // Long nib_valid high: a single capture
        set_mode(1'b1);
        send_nib(4'h9, 10);
        send_nib(4'h6);
        set_mode(1'b0);
        obs("edge_pc0", 4'h0);

        // Exit racing a low-nibble strobe
        set_mode(1'b1);
        send_nib(4'h3);
        race(4'h4);
        obs("race_pc0", 4'h0);

        // Sixteen words with wrap-around
        set_mode(1'b1);
        for (int i = 0; i < 16; i++) send_word(8'h10 + 8'(i));
        obs("wrap_addr0", 4'hF);
        set_mode(1'b0);
        obs("wrap_pc15", 4'hF);
        for (int i = 0; i < 16; i++) obs("wrap_sweep", 4'(i));

        // Randomised loads, sometimes abandoning a half word
        for (int r = 0; r < 4; r++) begin
            set_mode(1'b1);
            n = $urandom_range(1, 20);
            for (int i = 0; i < n; i++) send_word(8'($urandom));
            if ($urandom_range(0, 1) == 1) send_nib(4'($urandom));
            set_mode(1'b0);
            for (int i = 0; i < 8; i++) obs("rand_fetch", 4'($urandom));
        end

        // Reset in the middle of a load
        set_mode(1'b1);
        send_word(8'($urandom) | 8'h01);
        send_nib(4'($urandom));
        do_reset();

        repeat (3) tick();
        checks++;
        if (wrap_q.size() == 0 && obs_q.size() == 0) passes++;
        else $display("FAIL pending: got %0d wraps %0d observations outstanding required 0",
                      wrap_q.size(), obs_q.size());
        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule
